// File: rtl/hm_mem_pkg.sv
// Shared definitions for the dual-port byte-lane memory: init FSM encoding
// and parameter defaults.
package hm_mem_pkg;
  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_t;

  localparam int DW_DEF          = 32;
  localparam int AW_DEF          = 12;
  localparam int OUT_REG_DEF     = 0;
  localparam int WRITE_FIRST_DEF = 0;
  localparam int INIT_ZERO_DEF   = 1;
endpackage

// File: rtl/hm_memory_lane.sv
// One 8-bit byte lane of the dual-port memory. The enable on each port gates
// only the read register; the write strobe is qualified by the caller.
module hm_memory_lane #(
  parameter int AW          = 4,
  parameter int WRITE_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_di,
  output logic [7:0]    a_q,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_di,
  output logic [7:0]    b_q
);
  logic [7:0] mem [0:(1<<AW)-1];

  // Caller never lets both ports write the same word in one cycle.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_di;
    if (a_we) mem[a_addr] <= a_di;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_en) a_q <= (WRITE_FIRST != 0 && a_we) ? a_di : mem[a_addr];
      if (b_en) b_q <= (WRITE_FIRST != 0 && b_we) ? b_di : mem[b_addr];
    end
  end
endmodule

// File: rtl/hm_memory_dp.sv
// True dual-port byte-writable memory built from 8-bit lanes, with an init
// FSM that zero-fills the array after reset and an optional output stage.
module hm_memory_dp
  import hm_mem_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int OUT_REG     = OUT_REG_DEF,
  parameter int WRITE_FIRST = WRITE_FIRST_DEF,
  parameter int INIT_ZERO   = INIT_ZERO_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            a_en,
  input  logic [DW/8-1:0] a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_di,
  output logic [DW-1:0]   a_do,
  input  logic            b_en,
  input  logic [DW/8-1:0] b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_di,
  output logic [DW-1:0]   b_do,
  output logic            busy
);
  localparam int            NL   = DW / 8;
  localparam logic [AW-1:0] LAST = '1;

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      if (INIT_ZERO == 0 || cnt == LAST) state <= IDLE;
      cnt <= cnt + 1'b1;
    end
  end

  assign busy = (state == INIT);

  logic clr, go, a_acc, b_acc, same;
  assign clr   = (state == INIT) && (INIT_ZERO != 0) && !sys_rst;
  assign go    = (state == IDLE) && !sys_rst;
  assign a_acc = go & a_en;
  assign b_acc = go & b_en;
  assign same  = (a_addr == b_addr);

  // Stage p1: lane RAM read registers
  logic [DW-1:0] a_q_p1, b_q_p1;

  for (genvar k = 0; k < NL; k++) begin : g_lane
    logic          la_we, lb_we;
    logic [AW-1:0] la_addr;
    logic [7:0]    la_di;

    // Port A carries the init clear; on a same-word collision A owns shared lanes.
    assign la_we   = clr | (a_acc & a_we[k]);
    assign la_addr = clr ? cnt : a_addr;
    assign la_di   = clr ? 8'h00 : a_di[8*k +: 8];
    assign lb_we   = b_acc & b_we[k] & ~(a_acc & a_we[k] & same);

    hm_memory_lane #(.AW(AW), .WRITE_FIRST(WRITE_FIRST)) u_lane (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .a_en   (a_acc),
      .a_we   (la_we),
      .a_addr (la_addr),
      .a_di   (la_di),
      .a_q    (a_q_p1[8*k +: 8]),
      .b_en   (b_acc),
      .b_we   (lb_we),
      .b_addr (b_addr),
      .b_di   (b_di[8*k +: 8]),
      .b_q    (b_q_p1[8*k +: 8])
    );
  end

  // Stage p2: optional output register, loaded only behind an enabled access
  if (OUT_REG != 0) begin : g_oreg
    logic          vld_a_p1, vld_b_p1;
    logic [DW-1:0] a_do_p2, b_do_p2;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        vld_a_p1 <= 1'b0;
        vld_b_p1 <= 1'b0;
        a_do_p2  <= '0;
        b_do_p2  <= '0;
      end else begin
        vld_a_p1 <= a_acc;
        vld_b_p1 <= b_acc;
        if (vld_a_p1) a_do_p2 <= a_q_p1;
        if (vld_b_p1) b_do_p2 <= b_q_p1;
      end
    end

    assign a_do = a_do_p2;
    assign b_do = b_do_p2;
  end else begin : g_noreg
    assign a_do = a_q_p1;
    assign b_do = b_q_p1;
  end
endmodule
